running_add1: RTL and testbench
===============================

// Module: running_add1
// PURPOSE
//  Running-sum accumulator on a sample stream: each valid 16-bit unsigned input is
//  added to a wide sum, and the updated sum is emitted with a valid strobe.
//  Optional sliding-window mode sums only the most recent WINDOW accepted samples.
//  Sits after a sample source and feeds a logger/consumer of per-sample totals.
// PARAMETERS
//  IN_W    16   input sample width (unsigned)
//  OUT_W   256  sum/output width
//  WINDOW  0    0 = cumulative sum since reset; N>0 (N<=256) = sum of last N accepted samples
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      asynchronous, active-low reset (0 = reset asserted)
//  i_data        in   IN_W   input sample, unsigned
//  i_data_valid  in   1      i_data qualifier; sample accepted on a clock edge when 1
//  o_data        out  OUT_W  running sum including the latest accepted sample
//  o_data_valid  out  1      one-cycle strobe per accepted sample
// BEHAVIOUR
//  - Reset (reset==0, async): sum, o_data, o_data_valid, window buffer, fill count
//    and write pointer all cleared to 0 immediately, held while asserted.
//  - No handshake back-pressure: every edge with i_data_valid==1 accepts i_data.
//  - Latency 1 cycle: sample accepted at edge k -> o_data/o_data_valid valid after edge k.
//  - o_data_valid = registered i_data_valid; high exactly one cycle per accepted sample,
//    back-to-back for consecutive valid cycles.
//  - When i_data_valid==0: sum unchanged, o_data holds last value, o_data_valid=0.
//  - Cumulative mode (WINDOW==0): sum <= sum + zero_extend(i_data); o_data <= new sum.
//  - Window mode (WINDOW>0): circular buffer of WINDOW x IN_W samples plus fill count.
//    While fill < WINDOW: sum <= sum + new, store at wptr, fill++.
//    When full: sum <= sum + new - buf[wptr] (oldest), overwrite buf[wptr].
//    wptr increments on each accept, wraps WINDOW-1 -> 0.
//  - Arithmetic unsigned, modulo 2^OUT_W (wrap, no saturation/flag); in window mode the
//    sum never exceeds WINDOW*(2^IN_W-1), so no wrap occurs.
//  - Reset mid-stream discards all history; first sample after release restarts sum.
//  - Reset released coincident with i_data_valid==1: sample accepted normally on that edge.
//  - Output registers only; no combinational path from inputs to outputs.
// TESTING
//  - Reset held low, valid toggling -> o_data=0, o_data_valid=0 throughout.
//  - WINDOW=0, inputs 1..10 on consecutive valid cycles -> o_data 1,3,6,10,15,21,28,36,45,55,
//    each one cycle after its input, o_data_valid high for 10 consecutive cycles.
//  - WINDOW=0, 10 samples of 65535 -> final o_data=655350; upper 236 bits stay 0.
//  - WINDOW=0, valid gaps (5, idle 3 cycles, 7) -> 5, then held 5 with valid=0, then 12.
//  - WINDOW=4, inputs 1..6 -> o_data 1,3,6,10,14,18 (oldest dropped after 4th).
//  - Reset pulsed low after inputs 10,20 (sum 30), then input 4 -> o_data=4, async clear
//    observed without a clock edge.

Source files
------------

// File: rtl/running_add1.sv
// Running-sum accumulator: adds each accepted unsigned sample into a wide sum and
// strobes the updated total one cycle later. WINDOW>0 limits the sum to the last WINDOW samples.
module running_add1 #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 256,
    parameter int WINDOW = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_data_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_data_valid
);

    logic [OUT_W-1:0] sum_q;
    logic [OUT_W-1:0] sum_d;
    logic             valid_q;
    logic [OUT_W-1:0] new_ext;

    assign new_ext = {{(OUT_W-IN_W){1'b0}}, i_data};

    generate
        if (WINDOW == 0) begin : g_cumulative
            always_comb begin
                sum_d = sum_q + new_ext;
            end
        end else begin : g_window
            localparam int PTR_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
            localparam int FILL_W = $clog2(WINDOW + 1);

            logic [IN_W-1:0]   buf_q [WINDOW];
            logic [PTR_W-1:0]  wptr_q;
            logic [PTR_W-1:0]  wptr_d;
            logic [FILL_W-1:0] fill_q;
            logic              full;
            logic [OUT_W-1:0]  oldest_ext;

            assign full       = (fill_q == FILL_W'(WINDOW));
            assign oldest_ext = {{(OUT_W-IN_W){1'b0}}, buf_q[wptr_q]};

            // Once the window is full, the slot about to be overwritten holds the oldest sample.
            always_comb begin
                sum_d = sum_q + new_ext;
                if (full) begin
                    sum_d = sum_q + new_ext - oldest_ext;
                end
            end

            always_comb begin
                wptr_d = wptr_q + PTR_W'(1);
                if (wptr_q == PTR_W'(WINDOW - 1)) begin
                    wptr_d = '0;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    wptr_q <= '0;
                    fill_q <= '0;
                end else if (i_data_valid) begin
                    wptr_q <= wptr_d;
                    if (!full) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                end
            end

            for (genvar gi = 0; gi < WINDOW; gi++) begin : g_buf
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        buf_q[gi] <= '0;
                    end else if (i_data_valid && (wptr_q == PTR_W'(gi))) begin
                        buf_q[gi] <= i_data;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_data_valid;
            if (i_data_valid) begin
                sum_q <= sum_d;
            end
        end
    end

    assign o_data       = sum_q;
    assign o_data_valid = valid_q;

endmodule

// File: tb/tb_running_add1.sv
// Checks a cumulative instance and a 4-deep window instance side by side against
// plain-arithmetic reference sums, using directed and random sample streams.
module tb_running_add1;

    logic         clk;
    logic         rst_n;
    logic [15:0]  din;
    logic         din_valid;
    logic [255:0] cum_data;
    logic         cum_valid;
    logic [255:0] win_data;
    logic         win_valid;

    int passed;
    int total;

    logic [255:0] cum_exp;
    int unsigned  win_hist[$];
    logic         exp_valid;

    running_add1 #(.IN_W(16), .OUT_W(256), .WINDOW(0)) u_cum (
        .clock        (clk),
        .reset        (rst_n),
        .i_data       (din),
        .i_data_valid (din_valid),
        .o_data       (cum_data),
        .o_data_valid (cum_valid)
    );

    running_add1 #(.IN_W(16), .OUT_W(256), .WINDOW(4)) u_win (
        .clock        (clk),
        .reset        (rst_n),
        .i_data       (din),
        .i_data_valid (din_valid),
        .o_data       (win_data),
        .o_data_valid (win_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] win_exp();
        logic [255:0] s;
        s = '0;
        foreach (win_hist[i]) s = s + 256'(win_hist[i]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_cum_data"},  cum_data, cum_exp);
        check({tag, "_cum_valid"}, 256'(cum_valid), 256'(exp_valid));
        check({tag, "_win_data"},  win_data, win_exp());
        check({tag, "_win_valid"}, 256'(win_valid), 256'(exp_valid));
        $display("txn %-8s v=%0b d=%0d cum=%0d win=%0d", tag, din_valid, din, cum_data, win_data);
    endtask

    // One clock: drive at negedge, update the reference at posedge, compare 1 time unit later.
    task automatic step(input string tag, input logic v, input logic [15:0] d, input logic release_rst);
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        din_valid = v;
        din       = d;
        @(posedge clk);
        exp_valid = v && rst_n;
        if (v && rst_n) begin
            cum_exp = cum_exp + 256'(d);
            win_hist.push_back(int'(d));
            if (win_hist.size() > 4) void'(win_hist.pop_front());
        end
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges and confirm the clear happens without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        cum_exp   = '0;
        exp_valid = 1'b0;
        win_hist.delete();
        check_all(tag);
        step(tag, 1'b1, 16'd99, 1'b0);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        cum_exp   = '0;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = '0;

        for (int i = 0; i < 4; i++) step("inrst", i[0], 16'(i + 3), 1'b0);

        step("release", 1'b0, 16'd0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step("seq", 1'b1, 16'(k), 1'b0);
            if (k == 6) check("win_1to6_final", win_data, 256'd18);
        end
        check("cum_1to10_final", cum_data, 256'd55);

        async_reset("rst_a");
        step("release", 1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 10; k++) step("max", 1'b1, 16'hFFFF, 1'b0);
        check("cum_max_final", cum_data, 256'd655350);
        check("cum_max_upper", 256'(cum_data[255:20]), 256'd0);
        check("win_max_final", win_data, 256'd262140);

        async_reset("rst_b");
        step("release", 1'b0, 16'd0, 1'b1);
        step("gap5", 1'b1, 16'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("idle", 1'b0, 16'(100 + i), 1'b0);
            check("gap_hold", cum_data, 256'd5);
        end
        step("gap7", 1'b1, 16'd7, 1'b0);
        check("gap_final", cum_data, 256'd12);

        async_reset("rst_c");
        step("release", 1'b0, 16'd0, 1'b1);
        step("mid10", 1'b1, 16'd10, 1'b0);
        step("mid20", 1'b1, 16'd20, 1'b0);
        check("mid_sum30", cum_data, 256'd30);
        async_reset("rst_mid");
        check("mid_cleared", cum_data, 256'd0);
        step("release", 1'b0, 16'd0, 1'b1);
        step("mid4", 1'b1, 16'd4, 1'b0);
        check("mid_restart", cum_data, 256'd4);

        async_reset("rst_d");
        step("relvalid", 1'b1, 16'd9, 1'b1);
        check("release_accept", cum_data, 256'd9);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                async_reset("rst_rnd");
                step("release", 1'b0, 16'd0, 1'b1);
            end
            step("rnd", ($urandom_range(0, 3) != 0), 16'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
